muldiv_sequencer: RTL and testbench
===================================

Name: muldiv_sequencer

Overview:
- Multi-cycle HI/LO multiply/divide unit for the MIPS core.
- Sequences one radix-2 shift/add-subtract datapath for MULT, MULTU, DIV and DIVU, and handles MTHI/MTLO writes.
- Owns the architectural HI/LO registers.
- The main pipeline or single-cycle controller issues a one-cycle start, then stalls MFHI/MFLO while busy is high.

Parameters:
- DATA_W, 32, operand/HI/LO width; iteration count equals DATA_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  issue strobe, sampled on rising clk; ignored while busy=1.
- op  input  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved (no-op).
- rs_val  input  DATA_W  operand A (multiplicand/dividend/MTxx source).
- rt_val  input  DATA_W  operand B (multiplier/divisor).
- cancel  input  1  exception flush; aborts an in-flight operation.
- busy  output  1  registered; high while an operation is in flight.
- done  output  1  registered one-cycle pulse when HI/LO take a mult/div result.
- hi  output  DATA_W  HI register.
- lo  output  DATA_W  LO register.

Behaviour:
- One clock (clk); reset is asynchronous and active-low (rst_n).
- Reset state: state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0. Reset mid-operation drops the operation immediately; nothing is written.
- States:
  - IDLE: start=1 with op=MULT/MULTU/DIV/DIVU latches the operands (absolute values for signed ops) and records the result signs, then goes to RUN with counter=0 and busy=1 at the same edge.
  - start=1 with MTHI (MTLO) writes hi (lo) = rs_val at that edge; stays IDLE, busy stays 0, done stays 0.
  - start=1 with reserved op: no effect.
  - RUN: one iteration per cycle, counter increments. After DATA_W iterations (counter==DATA_W-1 at the edge) go to FIXUP.
  - FIXUP: apply signs, write hi/lo, go to IDLE. busy=0 and done=1 for exactly one cycle after this edge.
- Latency: start accepted at edge E0; hi/lo valid and done=1 after edge E(DATA_W+1) (E33 for DATA_W=32); busy=1 for DATA_W+1 cycles.
- Multiply: full 2*DATA_W product, hi=upper half, lo=lower half. MULT negates the 64-bit product when sign(rs) XOR sign(rt).
- Divide: restoring, unsigned magnitudes; lo=quotient, hi=remainder. Signed: quotient negated if signs differ; remainder takes the dividend's sign (truncation toward zero).
- Divide by zero (rt_val==0, DIV or DIVU): normal latency; lo=all ones, hi=rs_val unmodified.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no trap).
- start while busy: ignored, including MTHI/MTLO; the issuer must hold off.
- cancel=1 in RUN or FIXUP: next state IDLE, busy=0, done=0, hi/lo unchanged.
- cancel=1 in IDLE: suppresses a same-cycle start (cancel wins over start).
- start in the same cycle done=1 (state already IDLE): accepted normally, back-to-back.
- hi/lo change only at FIXUP, at MTHI/MTLO, or at reset.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then DIVU rs=100, rt=0 -> lo=0xFFFFFFFF, hi=100.
- MTHI rs=0x12345678 while idle -> hi updates next edge, busy stays 0, no done. Same MTHI issued while busy -> hi unchanged.
- Start DIVU 1000/3, assert cancel at cycle 10 -> busy falls next edge, no done, hi/lo keep prior values. Immediate new MULTU 5*6 -> lo=30, hi=0.
- Drive rst_n low mid-RUN, asynchronously between edges -> busy, done, hi, lo all 0 immediately. After release, MULT 2*3 -> lo=6.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// HI/LO multiply/divide unit: one radix-2 shift/add-subtract datapath sequenced over
// DATA_W iterations for MULT/MULTU/DIV/DIVU, plus MTHI/MTLO register writes.
module muldiv_sequencer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              cancel,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIXUP} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   counter;
  logic [DATA_W-1:0]  acc_hi, acc_lo, opb, rs_raw;
  logic               is_div, neg_q, neg_r, div_zero;

  logic               accept, md_op, signed_op, sign_a, sign_b;
  logic [DATA_W-1:0]  mag_a, mag_b;
  logic [DATA_W:0]    mul_sum, rem_sh, diff;
  logic signed [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]  res_hi, res_lo;

  function automatic logic [DATA_W-1:0] neg_word(input logic [DATA_W-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic signed [2*DATA_W-1:0] neg_dword(input logic [2*DATA_W-1:0] v,
                                                           input logic en);
    return en ? $signed(~v + 1'b1) : $signed(v);
  endfunction

  assign accept    = (state == IDLE) && start && !cancel;
  assign md_op     = !op[2];
  assign signed_op = !op[0];
  assign sign_a    = signed_op && rs_val[DATA_W-1];
  assign sign_b    = signed_op && rt_val[DATA_W-1];
  assign mag_a     = neg_word(rs_val, sign_a);
  assign mag_b     = neg_word(rt_val, sign_b);

  // Multiply step: conditional add of the multiplicand, then shift the product right.
  assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : {(DATA_W+1){1'b0}});
  // Restoring divide step: shift the next dividend bit into the remainder and trial-subtract.
  assign rem_sh  = {acc_hi, acc_lo[DATA_W-1]};
  assign diff    = rem_sh - {1'b0, opb};

  assign prod_fix = neg_dword({acc_hi, acc_lo}, neg_q);

  always_comb begin
    res_hi = prod_fix[2*DATA_W-1:DATA_W];
    res_lo = prod_fix[DATA_W-1:0];
    if (is_div) begin
      res_hi = div_zero ? rs_raw : neg_word(acc_hi, neg_r);
      res_lo = div_zero ? {DATA_W{1'b1}} : neg_word(acc_lo, neg_q);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && md_op) state_nxt = RUN;
      RUN:     if (cancel) state_nxt = IDLE;
               else if (counter == CNT_W'(DATA_W-1)) state_nxt = FIXUP;
      FIXUP:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      counter <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state   <= state_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state == FIXUP) && !cancel;
      counter <= (state == RUN) ? counter + 1'b1 : '0;
      if (accept && op == 3'b100) hi <= rs_val;
      if (accept && op == 3'b101) lo <= rs_val;
      if (state == FIXUP && !cancel) begin
        hi <= res_hi;
        lo <= res_lo;
      end
    end
  end

  // Datapath registers carry no reset; they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (accept && md_op) begin
      acc_hi   <= '0;
      acc_lo   <= mag_a;
      opb      <= mag_b;
      is_div   <= op[1];
      neg_q    <= sign_a ^ sign_b;
      neg_r    <= sign_a;
      div_zero <= op[1] && (rt_val == '0);
      rs_raw   <= rs_val;
    end else if (state == RUN) begin
      if (is_div) begin
        acc_hi <= diff[DATA_W] ? rem_sh[DATA_W-1:0] : diff[DATA_W-1:0];
        acc_lo <= {acc_lo[DATA_W-2:0], ~diff[DATA_W]};
      end else begin
        acc_hi <= mul_sum[DATA_W:1];
        acc_lo <= {mul_sum[0], acc_lo[DATA_W-1:1]};
      end
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: vector table, hand-written corner sequences,
// and randomized operations compared against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [2:0] OP_MULT = 3'b000, OP_MULTU = 3'b001, OP_DIV = 3'b010,
                         OP_DIVU = 3'b011, OP_MTHI = 3'b100, OP_MTLO = 3'b101,
                         OP_RSV = 3'b110;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] rs_val, rt_val;
  logic         cancel;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.DATA_W(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e_hi;
    logic [W-1:0] e_lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: full-width integer arithmetic, C-style truncating signed division.
  function automatic logic [63:0] model(input logic [2:0] o, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (o)
      OP_MULT:  return 64'(sa * sb);
      OP_MULTU: return ua * ub;
      OP_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {32'(ua % ub), 32'(ua / ub)};
      end
    endcase
  endfunction

  // Called at a negedge; the following posedge samples the strobe.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(output int bc, output int lat);
    bc  = 0;
    lat = -1;
    for (int i = 0; i < 100; i++) begin
      if (busy) bc++;
      if (done) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_op(input string nm, input logic [2:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int bc, lat;
    issue(o, a, b);
    wait_done(bc, lat);
    chk({nm, " latency"}, 64'(lat), 64'd33);
    chk({nm, " busy_cycles"}, 64'(bc), 64'd33);
    chk({nm, " hi"}, 64'(hi), 64'(eh));
    chk({nm, " lo"}, 64'(lo), 64'(el));
  endtask

  initial begin
    int bc, lat, done_seen;
    logic [63:0] m;
    logic [2:0] ro;
    logic [W-1:0] ra, rb;

    vecs[0] = '{OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{OP_DIVU,  32'd100,       32'd0,        32'd100,       32'hFFFF_FFFF};
    vecs[4] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000};
    vecs[5] = '{OP_DIVU,  32'd1000,      32'd3,        32'd1,         32'd333};
    vecs[6] = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
    vecs[7] = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8] = '{OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9] = '{OP_MULT,  32'd12345,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7};

    rst_n = 1'b0; start = 1'b0; op = '0; rs_val = '0; rt_val = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Vector table, issued back-to-back on the done cycle.
    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e_hi, vecs[i].e_lo);
    @(negedge clk);
    chk("done one-cycle", 64'(done), 64'd0);

    // MTHI / MTLO / reserved while idle.
    issue(OP_MTHI, 32'h1234_5678, 32'h0);
    chk("mthi hi", 64'(hi), 64'h1234_5678);
    chk("mthi lo kept", 64'(lo), 64'hFFFF_CFC7);
    chk("mthi busy", 64'(busy), 64'd0);
    chk("mthi done", 64'(done), 64'd0);
    issue(OP_MTLO, 32'hCAFE_F00D, 32'h0);
    chk("mtlo lo", 64'(lo), 64'hCAFE_F00D);
    chk("mtlo hi kept", 64'(hi), 64'h1234_5678);
    issue(OP_RSV, 32'h0000_FFFF, 32'h0);
    chk("rsv hi", 64'(hi), 64'h1234_5678);
    chk("rsv lo", 64'(lo), 64'hCAFE_F00D);
    chk("rsv busy", 64'(busy), 64'd0);

    // MTHI issued while busy is ignored and does not restart the operation.
    issue(OP_MULTU, 32'd5, 32'd6);
    repeat (3) @(negedge clk);
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'h0);
    chk("busy mthi hi", 64'(hi), 64'h1234_5678);
    wait_done(bc, lat);
    chk("busy mthi latency", 64'(lat), 64'd29);
    chk("busy mthi res hi", 64'(hi), 64'd0);
    chk("busy mthi res lo", 64'(lo), 64'd30);

    // Cancel mid-RUN.
    issue(OP_MTHI, 32'hAAAA_5555, 32'h0);
    issue(OP_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    chk("cancel busy", 64'(busy), 64'd0);
    chk("cancel done", 64'(done), 64'd0);
    done_seen = 0;
    repeat (40) begin
      if (done) done_seen++;
      @(negedge clk);
    end
    chk("cancel no done", 64'(done_seen), 64'd0);
    chk("cancel hi kept", 64'(hi), 64'hAAAA_5555);
    chk("cancel lo kept", 64'(lo), 64'd30);
    run_op("after cancel", OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

    // Cancel in IDLE wins over a same-cycle start.
    cancel = 1'b1;
    issue(OP_MTLO, 32'h77, 32'h0);
    chk("idle cancel mtlo", 64'(lo), 64'd30);
    issue(OP_MULT, 32'd9, 32'd9);
    cancel = 1'b0;
    chk("idle cancel busy", 64'(busy), 64'd0);

    // Asynchronous reset mid-RUN.
    issue(OP_MULTU, 32'hFFFF, 32'hFFFF);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst busy", 64'(busy), 64'd0);
    chk("async rst done", 64'(done), 64'd0);
    chk("async rst hi", 64'(hi), 64'd0);
    chk("async rst lo", 64'(lo), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post reset", OP_MULT, 32'd2, 32'd3, 32'd0, 32'd6);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ro = 3'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      if ($urandom_range(0, 3) == 0) rb = $urandom_range(1, 15);
      if ($urandom_range(0, 7) == 0) rb = '0;
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      m = model(ro, ra, rb);
      run_op($sformatf("rand%0d op%0d %h %h", i, ro, ra, rb), ro, ra, rb, m[63:32], m[31:0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
